elevator_car_controller: RTL and testbench
==========================================

ELEVATOR_CAR_CONTROLLER -- requirements
Module: elevator_car_controller

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (2..16).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 8, clocks to move one floor (>=1).
REQ-003 SHALL have parameter DOOR_CYCLES, default 6, clocks the door stays open (>=1).
REQ-004 SHALL have port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: requests  input  NUM_FLOORS  latched per-floor request flags from the request detectors.
REQ-007 SHALL have port: request_clear  output  NUM_FLOORS  one-cycle pulse clearing the serviced floor's request.
REQ-008 SHALL have port: current_floor  output  4  floor index of the car.
REQ-009 SHALL have port: moving_up, moving_down, door_open  output  1 each  car status.
REQ-010 SHALL have port: ctrl_state  output  2  FSM state for debug/LED display.

Function
REQ-011 SHALL implement FSM states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; all outputs registered.
REQ-012 IDLE: request at current_floor -> DOOR_OPEN next cycle, taking precedence over moves.
REQ-013 IDLE: else requests both above and below -> direction equals last_dir (MOVE_UP after reset); only above -> MOVE_UP; only below -> MOVE_DOWN; none -> stay IDLE.
REQ-014 On MOVE entry, the travel counter SHALL load TRAVEL_CYCLES-1 and decrement each cycle; on the cycle it is 0, current_floor SHALL step by +/-1.
REQ-015 After the step: request at the new floor -> DOOR_OPEN; else further requests in the same direction -> remain moving and reload the counter; else -> IDLE.
REQ-016 On every transition into DOOR_OPEN, request_clear SHALL pulse high for exactly one cycle on the bit of the floor being serviced, with all other bits 0.
REQ-017 DOOR_OPEN SHALL last DOOR_CYCLES cycles and then return to IDLE; a new request at current_floor during DOOR_OPEN SHALL re-pulse request_clear and restart the door count.
REQ-018 The car SHALL never step below floor 0 or above NUM_FLOORS-1; requests bits at or above NUM_FLOORS SHALL be ignored.
REQ-019 last_dir SHALL update on each MOVE entry; moving_up/moving_down SHALL be high only in their MOVE state; door_open SHALL be high only in DOOR_OPEN.
REQ-020 Requests that change during a move SHALL be re-evaluated at each floor step (REQ-015), not at the start of the move.

Reset
REQ-021 reset high at a rising edge SHALL force IDLE, current_floor=0, last_dir=up, counters=0, request_clear=0, and all status outputs 0 on the next cycle, including mid-move or mid-door.
REQ-022 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-023 With ELEVATOR_ESTOP_EN defined, the block SHALL add input estop (1 bit); while estop=1 the state, floor, and counters SHALL freeze, moving_up/moving_down SHALL be forced to 0, and no request_clear SHALL be issued; motion SHALL resume from the frozen counter value when estop is deasserted.
REQ-024 Without ELEVATOR_ESTOP_EN, the estop port and all of its logic SHALL be absent.

Structure
REQ-025 Package elevator_pkg SHALL hold the FSM state encoding (IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3), the FLOOR_W=4 constant, and the direction encoding.
REQ-026 A sub-module cycle_timer (loadable down-counter with zero flag) SHALL be instantiated, shared by the travel and door timing.

Verification (NUM_FLOORS=10, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-027 Reset, then requests=0000001000 -> MOVE_UP; current_floor 0->1->2->3 at 4-cycle intervals; at floor 3, request_clear=0000001000 for 1 cycle; door_open high for 3 cycles; then IDLE.
REQ-028 Car idle at floor 5 with requests at floors 7 and 2, last_dir=up -> services 7 first, then 2; two clear pulses, in that order.
REQ-029 While moving up from floor 0 to floor 6, floor 4 is requested before the car reaches it -> car stops at floor 4 (clear pulse on bit 4), then continues to 6.
REQ-030 Request at current floor 0 while idle -> DOOR_OPEN next cycle with request_clear[0] pulse; a second request at floor 0 during the door phase -> re-pulse and door_open extended to 3 cycles from the re-request.
REQ-031 Reset asserted mid-move between floors 3 and 4 -> next cycle current_floor=0, IDLE, all outputs 0.
REQ-032 With ELEVATOR_ESTOP_EN defined: estop held 5 cycles mid-travel -> floor and counter unchanged, moving_up=0; after release the floor step occurs at the remaining count.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller: FSM state and
// direction encodings, floor index width, and per-floor request mask helpers.
package elevator_pkg;

  localparam int FLOOR_W    = 4;
  localparam int MAX_FLOORS = 1 << FLOOR_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } car_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [MAX_FLOORS-1:0] m;
    m    = '0;
    m[f] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/elevator_car_controller_cycle_timer.sv
// Loadable down-counter with zero flag; one instance paces both floor travel
// and door dwell, since the car is never moving and door-open at once.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Single-car elevator controller: IDLE / MOVE_UP / MOVE_DOWN / DOOR_OPEN FSM.
// Optional emergency stop input is compiled in with ELEVATOR_ESTOP_EN.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 10,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] requests,
  output logic [NUM_FLOORS-1:0] request_clear,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [1:0]            ctrl_state
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  car_state_e             state_q, state_d;
  dir_e                   last_dir_q, last_dir_d;
  logic [FLOOR_W-1:0]     floor_q, floor_d;
  logic [NUM_FLOORS-1:0]  clear_q, clear_d;
  logic                   up_q, up_d, down_q, down_d, door_q, door_d;

  logic                   freeze;
  logic                   t_load, t_dec, t_zero;
  logic [CNT_W-1:0]       t_value;
  logic [MAX_FLOORS-1:0]  req_live;
  logic [FLOOR_W-1:0]     step_floor;
  logic                   here_req, above_here, below_here;
  logic                   step_req, step_above, step_below, at_limit;

`ifdef ELEVATOR_ESTOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  cycle_timer #(.W(CNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (t_load),
    .load_value (t_value),
    .dec        (t_dec),
    .zero       (t_zero)
  );

  // A request whose clear pulse is still in flight is already being serviced;
  // masking it stops the detector's one-cycle clear latency from re-triggering.
  always_comb begin
    req_live   = MAX_FLOORS'(requests & ~clear_q);
    step_floor = (state_q == MOVE_DOWN) ? (floor_q - FLOOR_W'(1)) : (floor_q + FLOOR_W'(1));
    here_req   = req_live[floor_q];
    above_here = |(req_live & above_mask(floor_q));
    below_here = |(req_live & below_mask(floor_q));
    step_req   = req_live[step_floor];
    step_above = |(req_live & above_mask(step_floor));
    step_below = |(req_live & below_mask(step_floor));
    at_limit   = ((state_q == MOVE_UP) && (floor_q == TOP_FLOOR)) ||
                 ((state_q == MOVE_DOWN) && (floor_q == '0));
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    last_dir_d = last_dir_q;
    clear_d    = '0;
    t_load     = 1'b0;
    t_value    = '0;
    t_dec      = 1'b0;

    if (!freeze) begin
      case (state_q)
        IDLE: begin
          if (here_req) begin
            state_d = DOOR_OPEN;
            clear_d = NUM_FLOORS'(floor_onehot(floor_q));
            t_load  = 1'b1;
            t_value = DOOR_LOAD;
          end else if (above_here && (!below_here || (last_dir_q == DIR_UP))) begin
            state_d    = MOVE_UP;
            last_dir_d = DIR_UP;
            t_load     = 1'b1;
            t_value    = TRAVEL_LOAD;
          end else if (below_here) begin
            state_d    = MOVE_DOWN;
            last_dir_d = DIR_DOWN;
            t_load     = 1'b1;
            t_value    = TRAVEL_LOAD;
          end
        end

        MOVE_UP, MOVE_DOWN: begin
          if (!t_zero) begin
            t_dec = 1'b1;
          end else if (at_limit) begin
            state_d = IDLE;
          end else begin
            floor_d = step_floor;
            if (step_req) begin
              state_d = DOOR_OPEN;
              clear_d = NUM_FLOORS'(floor_onehot(step_floor));
              t_load  = 1'b1;
              t_value = DOOR_LOAD;
            end else if ((state_q == MOVE_UP) ? step_above : step_below) begin
              t_load  = 1'b1;
              t_value = TRAVEL_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end

        DOOR_OPEN: begin
          if (here_req) begin
            clear_d = NUM_FLOORS'(floor_onehot(floor_q));
            t_load  = 1'b1;
            t_value = DOOR_LOAD;
          end else if (!t_zero) begin
            t_dec = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    up_d   = (state_d == MOVE_UP) && !freeze;
    down_d = (state_d == MOVE_DOWN) && !freeze;
    door_d = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      floor_q    <= '0;
      last_dir_q <= DIR_UP;
      clear_q    <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      door_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      last_dir_q <= last_dir_d;
      clear_q    <= clear_d;
      up_q       <= up_d;
      down_q     <= down_d;
      door_q     <= door_d;
    end
  end

  assign request_clear = clear_q;
  assign current_floor = floor_q;
  assign moving_up     = up_q;
  assign moving_down   = down_q;
  assign door_open     = door_q;
  assign ctrl_state    = state_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Scoreboard bench for elevator_car_controller (10 floors, travel 4, door 3);
// the estop scenario is compiled in with ELEVATOR_ESTOP_EN.
module tb_elevator_car_controller;

  localparam int K_FLOOR = 0;
  localparam int K_CLEAR = 1;
  localparam int K_DIR   = 2;
  localparam int K_DOOR  = 3;

  typedef struct {
    int kind;
    int value;
    int at;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       estop;
  logic [9:0] req_flags;
  logic [9:0] request_clear;
  logic [3:0] current_floor;
  logic       moving_up, moving_down, door_open;
  logic [1:0] ctrl_state;

  ev_t  sb_q[$];
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_floor;
  logic [1:0] prev_dir;
  int   door_len = 0;

  elevator_car_controller #(
    .NUM_FLOORS    (10),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
`ifdef ELEVATOR_ESTOP_EN
    .estop         (estop),
`endif
    .requests      (req_flags),
    .request_clear (request_clear),
    .current_floor (current_floor),
    .moving_up     (moving_up),
    .moving_down   (moving_down),
    .door_open     (door_open),
    .ctrl_state    (ctrl_state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  // Request detector: flags stay latched until the controller clears them.
  always @(negedge clock) req_flags = req_flags & ~request_clear;

  function automatic string kname(input int k);
    case (k)
      K_FLOOR: return "floor";
      K_CLEAR: return "clear";
      K_DIR:   return "dir";
      default: return "door_len";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic compare_ev(input int kind, input int value);
    ev_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL unexpected event %s=%0d at cycle %0d", kname(kind), value, cyc);
      return;
    end
    e = sb_q.pop_front();
    if (e.kind == kind && e.value == value && e.at == cyc) begin
      n_pass++;
      $display("ok   %s=%0d at cycle %0d", kname(kind), value, cyc);
    end else begin
      $display("FAIL event: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
               kname(kind), value, cyc, kname(e.kind), e.value, e.at);
    end
  endtask

  // Monitor: every observable change of the car becomes one event.
  always @(negedge clock) begin
    if (mon_en) begin
      if (current_floor != prev_floor) compare_ev(K_FLOOR, int'(current_floor));
      if (request_clear != '0) compare_ev(K_CLEAR, int'(request_clear));
      if ({moving_up, moving_down} != prev_dir) compare_ev(K_DIR, int'({moving_up, moving_down}));
      if (door_open) begin
        door_len++;
      end else if (door_len != 0) begin
        compare_ev(K_DOOR, door_len);
        door_len = 0;
      end
      prev_floor = current_floor;
      prev_dir   = {moving_up, moving_down};
    end
  end

  task automatic push_ev(input int kind, input int value, input int delay);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    e.at    = base + delay;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input logic [9:0] bits);
    @(negedge clock);
    base      = cyc;
    req_flags = req_flags | bits;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 300) begin
      @(posedge clock);
      w++;
    end
    repeat (4) @(negedge clock);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected events never seen", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctrl_state"},    int'(ctrl_state), 0);
    check({tag, " current_floor"}, int'(current_floor), 0);
    check({tag, " moving_up"},     int'(moving_up), 0);
    check({tag, " moving_down"},   int'(moving_down), 0);
    check({tag, " door_open"},     int'(door_open), 0);
    check({tag, " request_clear"}, int'(request_clear), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    estop     = 1'b0;
    req_flags = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset      = 1'b0;
    prev_floor = current_floor;
    prev_dir   = {moving_up, moving_down};
    mon_en     = 1'b1;

    // Floor 0 -> 3, door dwell, back to IDLE.
    set_req(10'h008);
    push_ev(K_DIR, 2, 1);
    push_ev(K_FLOOR, 1, 5);
    push_ev(K_FLOOR, 2, 9);
    push_ev(K_FLOOR, 3, 13);
    push_ev(K_CLEAR, 'h008, 13);
    push_ev(K_DIR, 0, 13);
    push_ev(K_DOOR, 3, 16);
    drain();

    // Floor 3 -> 5 so the car idles at 5 with last_dir up.
    set_req(10'h020);
    push_ev(K_DIR, 2, 1);
    push_ev(K_FLOOR, 4, 5);
    push_ev(K_FLOOR, 5, 9);
    push_ev(K_CLEAR, 'h020, 9);
    push_ev(K_DIR, 0, 9);
    push_ev(K_DOOR, 3, 12);
    drain();

    // Requests at 7 and 2 from floor 5: up to 7 first, then down to 2.
    set_req(10'h084);
    push_ev(K_DIR, 2, 1);
    push_ev(K_FLOOR, 6, 5);
    push_ev(K_FLOOR, 7, 9);
    push_ev(K_CLEAR, 'h080, 9);
    push_ev(K_DIR, 0, 9);
    push_ev(K_DOOR, 3, 12);
    push_ev(K_DIR, 1, 13);
    push_ev(K_FLOOR, 6, 17);
    push_ev(K_FLOOR, 5, 21);
    push_ev(K_FLOOR, 4, 25);
    push_ev(K_FLOOR, 3, 29);
    push_ev(K_FLOOR, 2, 33);
    push_ev(K_CLEAR, 'h004, 33);
    push_ev(K_DIR, 0, 33);
    push_ev(K_DOOR, 3, 36);
    drain();

    // Reset while travelling between floors 3 and 4.
    set_req(10'h010);
    push_ev(K_DIR, 2, 1);
    push_ev(K_FLOOR, 3, 5);
    repeat (7) @(negedge clock);
    reset     = 1'b1;
    req_flags = '0;
    base      = cyc;
    push_ev(K_FLOOR, 0, 1);
    push_ev(K_DIR, 0, 1);
    @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("midmove_reset");
    drain();

    // Floor 0 -> 6 with floor 4 requested on the way.
    set_req(10'h040);
    push_ev(K_DIR, 2, 1);
    push_ev(K_FLOOR, 1, 5);
    push_ev(K_FLOOR, 2, 9);
    push_ev(K_FLOOR, 3, 13);
    push_ev(K_FLOOR, 4, 17);
    push_ev(K_CLEAR, 'h010, 17);
    push_ev(K_DIR, 0, 17);
    push_ev(K_DOOR, 3, 20);
    push_ev(K_DIR, 2, 21);
    push_ev(K_FLOOR, 5, 25);
    push_ev(K_FLOOR, 6, 29);
    push_ev(K_CLEAR, 'h040, 29);
    push_ev(K_DIR, 0, 29);
    push_ev(K_DOOR, 3, 32);
    repeat (10) @(negedge clock);
    req_flags = req_flags | 10'h010;
    drain();

    // Back to floor 0, then a same-floor request re-issued during the door phase.
    @(negedge clock);
    reset     = 1'b1;
    req_flags = '0;
    base      = cyc;
    push_ev(K_FLOOR, 0, 1);
    @(negedge clock);
    reset = 1'b0;
    drain();
    set_req(10'h001);
    push_ev(K_CLEAR, 'h001, 1);
    push_ev(K_CLEAR, 'h001, 3);
    push_ev(K_DOOR, 5, 6);
    repeat (2) @(negedge clock);
    req_flags = req_flags | 10'h001;
    drain();

`ifdef ELEVATOR_ESTOP_EN
    // Emergency stop for 5 cycles mid-travel from floor 0 towards floor 2.
    set_req(10'h004);
    push_ev(K_DIR, 2, 1);
    push_ev(K_DIR, 0, 3);
    push_ev(K_DIR, 2, 8);
    push_ev(K_FLOOR, 1, 10);
    push_ev(K_FLOOR, 2, 14);
    push_ev(K_CLEAR, 'h004, 14);
    push_ev(K_DIR, 0, 14);
    push_ev(K_DOOR, 3, 17);
    repeat (2) @(negedge clock);
    estop = 1'b1;
    repeat (5) @(negedge clock);
    estop = 1'b0;
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
